// File: rtl/mul_cmd_scheduler.sv
// Command scheduler in front of MUL_controller: queues compute commands, issues them one at a
// time, and round-robin arbitrates two load/store requesters onto the ExLdSt port while holding
// off any access to a row owned by the in-flight compute command.
module mul_cmd_scheduler #(
  parameter int unsigned ROW_NUM  = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned CQ_DEPTH = 4,
  // Derived widths: {spec, mode, length, rs1, rs2, rd} and {wr, addr}
  parameter int unsigned CMD_W    = 7 + 3 * ADDR_W,
  parameter int unsigned LS_W     = 1 + ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  // Compute command queue from host
  input  logic               cq_valid,
  output logic               cq_ready,
  input  logic [CMD_W-1:0]   cq_command,
  // Requester A
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [LS_W-1:0]    a_command,
  input  logic [ROW_NUM-1:0] a_wdata,
  output logic [ROW_NUM-1:0] a_rdata,
  output logic               a_rvalid,
  // Requester B
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [LS_W-1:0]    b_command,
  input  logic [ROW_NUM-1:0] b_wdata,
  output logic [ROW_NUM-1:0] b_rdata,
  output logic               b_rvalid,
  // Load/store port to MUL_controller
  output logic               ExLdSt_valid,
  output logic [LS_W-1:0]    ExLdSt_command,
  output logic [ROW_NUM-1:0] ExLdSt_data_out,
  input  logic [ROW_NUM-1:0] ExLdSt_data_in,
  // Compute port to MUL_controller
  output logic               Compute_valid,
  input  logic               Compute_ready,
  output logic [CMD_W-1:0]   Compute_command,
  output logic               busy
);

  localparam int unsigned PtrW = $clog2(CQ_DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // ---------------------------------------------------------------------------
  // Compute command FIFO (extra pointer bit separates full from empty)
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] fifo_q [CQ_DEPTH];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // Held low while in reset so the host never sees a stale accept
  assign cq_ready = !fifo_full && !rst;
  assign push     = cq_valid && cq_ready;

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PtrW-1:0]] <= cq_command;
  end

  // ---------------------------------------------------------------------------
  // Compute issue FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CMD_W-1:0] act_q, act_d;

  // State and active-command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  end

  // Next-state: pop the head when idle, wait for Compute_ready when busy
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          act_d   = fifo_q[rd_ptr_q[PtrW-1:0]];
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (Compute_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Compute_valid   = (state_q == StBusy);
  assign Compute_command = Compute_valid ? act_q : '0;
  assign busy            = !fifo_empty || Compute_valid;

  // ---------------------------------------------------------------------------
  // Hazard check against the in-flight command's row operands
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] act_rd, act_rs2, act_rs1;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              a_wr, b_wr;
  logic              a_blocked, b_blocked;

  assign act_rd  = act_q[ADDR_W-1:0];
  assign act_rs2 = act_q[2*ADDR_W-1:ADDR_W];
  assign act_rs1 = act_q[3*ADDR_W-1:2*ADDR_W];

  assign a_addr = a_command[ADDR_W-1:0];
  assign a_wr   = a_command[ADDR_W];
  assign b_addr = b_command[ADDR_W-1:0];
  assign b_wr   = b_command[ADDR_W];

  // Reads and writes are both blocked: a read could see a half-computed row
  always_comb begin
    a_blocked = Compute_valid &&
                ((a_addr == act_rs1) || (a_addr == act_rs2) || (a_addr == act_rd));
    b_blocked = Compute_valid &&
                ((b_addr == act_rs1) || (b_addr == act_rs2) || (b_addr == act_rd));
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter (rr_q: 0 favours A, 1 favours B)
  // ---------------------------------------------------------------------------
  logic rr_q, rr_d;
  logic elig_a, elig_b;
  logic grant_a, grant_b;

  // Grant selection; the pointer only moves when both requesters contend
  always_comb begin
    elig_a  = a_valid && !a_blocked && !rst;
    elig_b  = b_valid && !b_blocked && !rst;
    grant_a = elig_a && (!elig_b || !rr_q);
    grant_b = elig_b && (!elig_a || rr_q);
    rr_d    = rr_q;
    if (elig_a && elig_b) rr_d = !rr_q;
  end

  // Arbiter pointer register
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Drive the ExLdSt port from the winner in the grant cycle
  always_comb begin
    ExLdSt_valid    = grant_a || grant_b;
    ExLdSt_command  = '0;
    ExLdSt_data_out = '0;
    if (grant_a) begin
      ExLdSt_command = a_command;
      if (a_wr) ExLdSt_data_out = a_wdata;
    end else if (grant_b) begin
      ExLdSt_command = b_command;
      if (b_wr) ExLdSt_data_out = b_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path: capture array data in the grant cycle, present it next cycle
  // ---------------------------------------------------------------------------
  logic               a_rvalid_q, b_rvalid_q;
  logic [ROW_NUM-1:0] a_rdata_q, b_rdata_q;

  // Read data capture and one-cycle rvalid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= grant_a && !a_wr;
      b_rvalid_q <= grant_b && !b_wr;
      if (grant_a && !a_wr) a_rdata_q <= ExLdSt_data_in;
      if (grant_b && !b_wr) b_rdata_q <= ExLdSt_data_in;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_mul_cmd_scheduler.sv
// Directed bench for mul_cmd_scheduler: a vector table for load/store arbitration and read
// return, plus hand-written sequences for compute issue, hazards, FIFO full and reset.
module tb_mul_cmd_scheduler;

  logic        clk;
  logic        rst;
  logic        cq_valid;
  logic        cq_ready;
  logic [24:0] cq_command;
  logic        a_valid, a_ready, a_rvalid;
  logic [6:0]  a_command;
  logic [15:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_rvalid;
  logic [6:0]  b_command;
  logic [15:0] b_wdata, b_rdata;
  logic        ExLdSt_valid;
  logic [6:0]  ExLdSt_command;
  logic [15:0] ExLdSt_data_out;
  logic [15:0] ExLdSt_data_in;
  logic        Compute_valid;
  logic        Compute_ready;
  logic [24:0] Compute_command;
  logic        busy;

  int n_pass;
  int n_total;

  mul_cmd_scheduler #(
    .ROW_NUM (16),
    .ADDR_W  (6),
    .CQ_DEPTH(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cq_valid       (cq_valid),
    .cq_ready       (cq_ready),
    .cq_command     (cq_command),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_command      (a_command),
    .a_wdata        (a_wdata),
    .a_rdata        (a_rdata),
    .a_rvalid       (a_rvalid),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_command      (b_command),
    .b_wdata        (b_wdata),
    .b_rdata        (b_rdata),
    .b_rvalid       (b_rvalid),
    .ExLdSt_valid   (ExLdSt_valid),
    .ExLdSt_command (ExLdSt_command),
    .ExLdSt_data_out(ExLdSt_data_out),
    .ExLdSt_data_in (ExLdSt_data_in),
    .Compute_valid  (Compute_valid),
    .Compute_ready  (Compute_ready),
    .Compute_command(Compute_command),
    .busy           (busy)
  );

  // Row array stand-in for MUL_controller: combinational read, write on the clock edge
  logic [15:0] bmem [64];
  assign ExLdSt_data_in = (ExLdSt_valid && !ExLdSt_command[6]) ? bmem[ExLdSt_command[5:0]]
                                                               : 16'h0000;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) bmem[i] <= 16'h0000;
    end else if (ExLdSt_valid && ExLdSt_command[6]) begin
      bmem[ExLdSt_command[5:0]] <= ExLdSt_data_out;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        av;
    logic [6:0]  acmd;
    logic [15:0] awd;
    logic        bv;
    logic [6:0]  bcmd;
    logic [15:0] bwd;
    logic        eag;
    logic        ebg;
    logic [6:0]  ecmd;
    logic [15:0] edat;
    logic        earv;
    logic [15:0] eard;
    logic        ebrv;
    logic [15:0] ebrd;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  localparam logic [24:0] C1 = 25'b0_010_010_000001_000010_000011;
  localparam logic [24:0] CM = 25'b0_010_000_000001_000010_000101;

  logic        ok;
  logic [24:0] fc [7];

  initial begin
    n_pass = 0;
    n_total = 0;
    // av acmd awd | bv bcmd bwd | eag ebg ecmd edat | earv eard | ebrv ebrd
    vecs[0]  = '{1'b1, 7'h41, 16'hAA55, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 7'h41, 16'hAA55,
                 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 7'h01, 16'h0000, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 7'h01, 16'h0000,
                 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 7'h00, 16'h0000, 1'b1, 7'h49, 16'h1234, 1'b0, 1'b1, 7'h49, 16'h1234,
                 1'b1, 16'hAA55, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 7'h43, 16'h0003, 1'b1, 7'h09, 16'h0000, 1'b1, 1'b0, 7'h43, 16'h0003,
                 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 7'h44, 16'h0004, 1'b1, 7'h09, 16'h0000, 1'b0, 1'b1, 7'h09, 16'h0000,
                 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 7'h44, 16'h0004, 1'b1, 7'h01, 16'h0000, 1'b1, 1'b0, 7'h44, 16'h0004,
                 1'b0, 16'h0000, 1'b1, 16'h1234};
    vecs[6]  = '{1'b0, 7'h00, 16'h0000, 1'b1, 7'h01, 16'h0000, 1'b0, 1'b1, 7'h01, 16'h0000,
                 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 7'h04, 16'h0000, 1'b1, 7'h03, 16'h0000, 1'b0, 1'b1, 7'h03, 16'h0000,
                 1'b0, 16'h0000, 1'b1, 16'hAA55};
    vecs[8]  = '{1'b1, 7'h04, 16'h0000, 1'b1, 7'h42, 16'h5555, 1'b1, 1'b0, 7'h04, 16'h0000,
                 1'b0, 16'h0000, 1'b1, 16'h0003};
    vecs[9]  = '{1'b1, 7'h01, 16'h0000, 1'b1, 7'h42, 16'h5555, 1'b0, 1'b1, 7'h42, 16'h5555,
                 1'b1, 16'h0004, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 7'h01, 16'h0000, 1'b1, 7'h02, 16'h0000, 1'b1, 1'b0, 7'h01, 16'h0000,
                 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 7'h03, 16'h0000, 1'b1, 7'h02, 16'h0000, 1'b0, 1'b1, 7'h02, 16'h0000,
                 1'b1, 16'hAA55, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 7'h03, 16'h0000, 1'b1, 7'h09, 16'h0000, 1'b1, 1'b0, 7'h03, 16'h0000,
                 1'b0, 16'h0000, 1'b1, 16'h5555};
    vecs[13] = '{1'b1, 7'h04, 16'h0000, 1'b1, 7'h09, 16'h0000, 1'b0, 1'b1, 7'h09, 16'h0000,
                 1'b1, 16'h0003, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 7'h00, 16'h0000, 1'b0, 7'h00, 16'h0000, 1'b0, 1'b0, 7'h00, 16'h0000,
                 1'b0, 16'h0000, 1'b1, 16'h1234};
    for (int k = 1; k <= 6; k++) fc[k] = 25'h100000 + 25'(k);
    fc[0] = 25'h0;

    rst = 1'b1;
    cq_valid = 1'b0;
    cq_command = '0;
    a_valid = 1'b0;
    a_command = '0;
    a_wdata = '0;
    b_valid = 1'b0;
    b_command = '0;
    b_wdata = '0;
    Compute_ready = 1'b0;

    // ---- Reset values ----
    cyc();
    a_valid = 1'b1;
    a_command = 7'h01;
    cq_valid = 1'b1;
    cq_command = C1;
    @(negedge clk);
    chk("rst_cq_ready_low", {31'd0, cq_ready}, 32'd0);
    chk("rst_a_ready_low", {31'd0, a_ready}, 32'd0);
    chk("rst_ex_valid_low", {31'd0, ExLdSt_valid}, 32'd0);
    cyc();
    rst = 1'b0;
    a_valid = 1'b0;
    a_command = '0;
    cq_valid = 1'b0;
    @(negedge clk);
    chk("rst_cq_ready_high", {31'd0, cq_ready}, 32'd1);
    chk("rst_compute_valid", {31'd0, Compute_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_compute_cmd", {7'd0, Compute_command}, 32'd0);
    chk("rst_a_rdata", {16'd0, a_rdata}, 32'd0);
    chk("rst_ex_cmd", {25'd0, ExLdSt_command}, 32'd0);

    // ---- Load/store vector table ----
    for (int i = 0; i < NV; i++) begin
      cyc();
      a_valid = vecs[i].av;
      a_command = vecs[i].acmd;
      a_wdata = vecs[i].awd;
      b_valid = vecs[i].bv;
      b_command = vecs[i].bcmd;
      b_wdata = vecs[i].bwd;
      @(negedge clk);
      chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].eag});
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].ebg});
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ExLdSt_valid},
          {31'd0, vecs[i].eag | vecs[i].ebg});
      chk($sformatf("v%0d_ex_cmd", i), {25'd0, ExLdSt_command}, {25'd0, vecs[i].ecmd});
      chk($sformatf("v%0d_ex_data", i), {16'd0, ExLdSt_data_out}, {16'd0, vecs[i].edat});
      chk($sformatf("v%0d_a_rvalid", i), {31'd0, a_rvalid}, {31'd0, vecs[i].earv});
      chk($sformatf("v%0d_b_rvalid", i), {31'd0, b_rvalid}, {31'd0, vecs[i].ebrv});
      if (vecs[i].earv) chk($sformatf("v%0d_a_rdata", i), {16'd0, a_rdata}, {16'd0, vecs[i].eard});
      if (vecs[i].ebrv) chk($sformatf("v%0d_b_rdata", i), {16'd0, b_rdata}, {16'd0, vecs[i].ebrd});
    end

    // ---- Compute issue: valid at t+2, stable, ready after 5 cycles ----
    cyc();
    cq_valid = 1'b1;
    cq_command = C1;
    @(negedge clk);
    chk("ci_cq_ready", {31'd0, cq_ready}, 32'd1);
    chk("ci_valid_t0", {31'd0, Compute_valid}, 32'd0);
    cyc();
    cq_valid = 1'b0;
    @(negedge clk);
    chk("ci_valid_t1", {31'd0, Compute_valid}, 32'd0);
    chk("ci_busy_t1", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      Compute_ready = (k == 5);
      @(negedge clk);
      chk($sformatf("ci_valid_c%0d", k), {31'd0, Compute_valid}, 32'd1);
      chk($sformatf("ci_cmd_c%0d", k), {7'd0, Compute_command}, {7'd0, C1});
    end
    cyc();
    Compute_ready = 1'b0;
    @(negedge clk);
    chk("ci_valid_fall", {31'd0, Compute_valid}, 32'd0);
    chk("ci_busy_fall", {31'd0, busy}, 32'd0);

    // ---- Hazard: A reads rd row, B writes free row, then B reads rs1 row ----
    cyc();
    a_valid = 1'b1;
    a_command = 7'h45;
    a_wdata = 16'h0F0F;
    @(negedge clk);
    chk("hz_pre_write", {31'd0, a_ready}, 32'd1);
    cyc();
    a_valid = 1'b0;
    cq_valid = 1'b1;
    cq_command = CM;
    @(negedge clk);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      cyc();
      cq_valid = 1'b0;
      @(negedge clk);
      if (Compute_valid) ok = 1'b1;
    end
    chk("hz_issue_seen", {31'd0, ok}, 32'd1);
    chk("hz_issue_cmd", {7'd0, Compute_command}, {7'd0, CM});
    cyc();
    a_valid = 1'b1;
    a_command = 7'h05;
    b_valid = 1'b1;
    b_command = 7'h49;
    b_wdata = 16'hBEEF;
    @(negedge clk);
    chk("hz_a_blocked", {31'd0, a_ready}, 32'd0);
    chk("hz_b_granted", {31'd0, b_ready}, 32'd1);
    chk("hz_b_cmd", {25'd0, ExLdSt_command}, 32'h49);
    cyc();
    b_command = 7'h01;
    b_wdata = 16'h0000;
    @(negedge clk);
    chk("hz_both_blocked_a", {31'd0, a_ready}, 32'd0);
    chk("hz_both_blocked_b", {31'd0, b_ready}, 32'd0);
    chk("hz_no_ex_valid", {31'd0, ExLdSt_valid}, 32'd0);
    cyc();
    Compute_ready = 1'b1;
    @(negedge clk);
    chk("hz_ready_cycle_a", {31'd0, a_ready}, 32'd0);
    chk("hz_ready_cycle_b", {31'd0, b_ready}, 32'd0);
    cyc();
    Compute_ready = 1'b0;
    @(negedge clk);
    chk("hz_release_valid", {31'd0, Compute_valid}, 32'd0);
    chk("hz_release_a", {31'd0, a_ready}, 32'd1);
    chk("hz_release_b", {31'd0, b_ready}, 32'd0);
    chk("hz_release_cmd", {25'd0, ExLdSt_command}, 32'h05);
    cyc();
    a_valid = 1'b0;
    @(negedge clk);
    chk("hz_b_after", {31'd0, b_ready}, 32'd1);
    chk("hz_b_after_cmd", {25'd0, ExLdSt_command}, 32'h01);
    chk("hz_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("hz_a_rdata", {16'd0, a_rdata}, 32'h0F0F);
    cyc();
    b_valid = 1'b0;
    b_command = '0;
    @(negedge clk);
    chk("hz_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("hz_b_rdata", {16'd0, b_rdata}, 32'hAA55);

    // ---- FIFO full: 1 active + 4 queued accepted, sixth refused ----
    for (int k = 1; k <= 6; k++) begin
      cyc();
      cq_valid = 1'b1;
      cq_command = fc[k];
      @(negedge clk);
      chk($sformatf("ff_cq_ready_%0d", k), {31'd0, cq_ready}, (k <= 5) ? 32'd1 : 32'd0);
    end
    cyc();
    cq_valid = 1'b0;
    @(negedge clk);
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("ff_valid_%0d", j), {31'd0, Compute_valid}, 32'd1);
      chk($sformatf("ff_cmd_%0d", j), {7'd0, Compute_command}, {7'd0, fc[j]});
      cyc();
      Compute_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("ff_hold_%0d", j), {7'd0, Compute_command}, {7'd0, fc[j]});
      cyc();
      Compute_ready = 1'b0;
      if (j == 1) begin
        cq_valid = 1'b1;
        cq_command = fc[6];
      end
      @(negedge clk);
      chk($sformatf("ff_gap_%0d", j), {31'd0, Compute_valid}, 32'd0);
      if (j == 1) chk("ff_full_during_pop", {31'd0, cq_ready}, 32'd0);
      cyc();
      cq_valid = 1'b0;
      @(negedge clk);
    end
    chk("ff_drained_valid", {31'd0, Compute_valid}, 32'd0);
    chk("ff_drained_busy", {31'd0, busy}, 32'd0);

    // ---- Reset during C_BUSY with two commands queued ----
    for (int k = 0; k < 3; k++) begin
      cyc();
      cq_valid = 1'b1;
      cq_command = 25'h1000011 * 25'(k + 1);
      @(negedge clk);
      chk($sformatf("mr_push_%0d", k), {31'd0, cq_ready}, 32'd1);
    end
    cyc();
    cq_valid = 1'b0;
    @(negedge clk);
    chk("mr_active", {31'd0, Compute_valid}, 32'd1);
    chk("mr_active_cmd", {7'd0, Compute_command}, 32'h1000011);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_cq_ready_in_rst", {31'd0, cq_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_valid_dropped", {31'd0, Compute_valid}, 32'd0);
    chk("mr_busy_clear", {31'd0, busy}, 32'd0);
    chk("mr_cq_ready_back", {31'd0, cq_ready}, 32'd1);
    chk("mr_cmd_zero", {7'd0, Compute_command}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("mr_no_stale_%0d", k), {31'd0, Compute_valid | busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
